ps2_host_tx: RTL
================

# ps2_host_tx

PS/2 host-to-device transmitter. It is the send side of the existing PS/2 keyboard receiver, used to send command bytes such as 0xED (set LEDs) or 0xFF (reset) to the keyboard. It drives the shared `ps2Clk`/`ps2Data` lines through open-drain enables and runs the full host-request sequence: inhibit, start, data, parity, stop, ack. It sits beside the `ps2` receiver in the top level, and `busy` gates that receiver.

## Interface
- `c_clk_mhz`, 25: `clk` frequency in MHz.
- `c_inhibit_us`, 120: clock-inhibit duration in µs. INHIBIT_CYC = c_clk_mhz*c_inhibit_us.
- `c_timeout_us`, 15000: limit from clock release to end of transfer. TIMEOUT_CYC = c_clk_mhz*c_timeout_us.
- `clk`  in  1  system clock, `clk_cpu` domain.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  send request; accepted when `tx_ready`=1.
- `tx_ready`  out  1  high only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse: byte sent and device acked.
- `error`  out  1  one-cycle pulse: no ack, or timeout.
- `ps2_clk_in`  in  1  raw clock pin level (asynchronous).
- `ps2_data_in`  in  1  raw data pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull clock low; 0 = release.
- `ps2_data_oe`  out  1  1 = pull data low; 0 = release.

## Operation
- Input conditioning: 2-FF synchronizer on each input. `fall` = previous synchronized clock high and current low.
- Frame shift register is 10 bits, LSB first: `{1'b1 stop, parity, tx_data}`. Parity is odd: parity = ~^tx_data.
- IDLE: both enables 0. On `tx_valid`:
  - latch the frame;
  - `ps2_clk_oe`<=1;
  - counter <= INHIBIT_CYC-1;
  - go to INHIBIT.
- INHIBIT: decrement the counter. At 0: `ps2_data_oe`<=1 (start bit) and go to RELEASE.
- RELEASE: one cycle in which data is low and clock is still held. Then `ps2_clk_oe`<=0, timeout counter <= 0, bit count <= 0, go to BITS.
- BITS: on each `fall`: `ps2_data_oe`<=~shift[0], shift right, bitcnt+1. Falls 1–8 present data bits, fall 9 parity, fall 10 stop (line released). After fall 10, go to ACK.
- ACK: on the next `fall`, latch ack_ok = ~synchronized data, then go to WAIT_IDLE.
- WAIT_IDLE: wait until both synchronized lines are high, then pulse `done` if ack_ok, otherwise `error`. Go to IDLE.
- Timeout: the timeout counter runs in BITS, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYC-1:
  - release both lines;
  - pulse `error`;
  - go to IDLE (no wait for idle lines).
- `tx_valid` while busy is ignored; no queuing.
- `fall` in IDLE, INHIBIT or RELEASE is ignored.
- Reset at any time: state IDLE and all outputs to reset values. Lines are released asynchronously.

## Timing
- Reset values:
  - `ps2_clk_oe`=0, `ps2_data_oe`=0;
  - `done`=0, `error`=0, `busy`=0;
  - `tx_ready`=1.
- `tx_valid` is sampled at edge N; `ps2_clk_oe`=1 and `busy`=1 from N+1.
- Clock held low for exactly INHIBIT_CYC+1 cycles. `ps2_data_oe` rises one cycle before `ps2_clk_oe` falls.
- `ps2_data_oe` update latency is 3 `clk` cycles after the pin's falling edge: 2 synchronizer cycles plus the register. At 25 MHz that is 120 ns, far inside the ≥30 µs PS/2 low phase.
- `done`/`error` are high for exactly one cycle. `tx_ready` returns in the cycle after the pulse.
- Counter widths: $clog2(INHIBIT_CYC) and $clog2(TIMEOUT_CYC) bits, both unsigned.

## Structure
- `ps2_pkg`:
  - state enum (IDLE, INHIBIT, RELEASE, BITS, ACK, WAIT_IDLE);
  - frame length constant 10;
  - odd-parity function, shared with the receiver.
- Sub-module `ps2_sync_edge`: 2-FF synchronizer plus falling-edge detector, one instance per line. It is reusable by the `ps2` receiver.

## Test plan
- Reset asserted mid-INHIBIT -> `ps2_clk_oe`=`ps2_data_oe`=0 immediately, `tx_ready`=1, no `done`/`error`.
- Send 0xED, device model clocking at 12.5 kHz, device acks -> data line sampled on rising edges reads 0,1,0,1,1,0,1,1,1,1,1 (start, LSB-first data, parity=1, stop). `done`=1 once, `error`=0.
- Send 0x01 -> parity bit 0. Clock low for exactly INHIBIT_CYC+1 cycles (3001 at defaults).
- Device leaves data high at fall 11 (no ack) -> `error` pulses once after both lines are high, `done` stays 0.
- Device never clocks after release -> `error` pulses exactly TIMEOUT_CYC cycles after `ps2_clk_oe` falls. Both enables 0, then IDLE.
- `tx_valid` with 0x55 pulsed during BITS of 0xED -> ignored; the transmitted frame is 0xED only, with a single `done`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame length and the
// odd-parity helper used by both the transmitter and the receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        BITS,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    // Data bits + parity + stop; the start bit is driven separately in RELEASE.
    localparam int FRAME_LEN = 10;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge detector on
// the synchronized level. Flops reset high to match the idle (pulled-up) bus.
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pin_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start bit,
// shifts out data/parity/stop on device clock falls and checks the device ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int c_clk_mhz    = 25,
    parameter int c_inhibit_us = 120,
    parameter int c_timeout_us = 15000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output ps2_state_t dbg_state
);

    localparam int INHIBIT_CYC = c_clk_mhz * c_inhibit_us;
    localparam int TIMEOUT_CYC = c_clk_mhz * c_timeout_us;
    localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_LEN - 1);

    logic clk_sync, clk_fall;
    logic data_sync, data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk    (clk),
        .reset  (reset),
        .pin_in (ps2_clk_in),
        .level  (clk_sync),
        .fall   (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk    (clk),
        .reset  (reset),
        .pin_in (ps2_data_in),
        .level  (data_sync),
        .fall   (data_fall_unused)
    );

    ps2_state_t           state_q, state_d;
    logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic                 ack_ok_q, ack_ok_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ack_ok_d  = ack_ok_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    shift_d   = {1'b1, odd_parity(tx_data), tx_data};
                    clk_oe_d  = 1'b1;
                    inh_cnt_d = INH_LOAD;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == '0) begin
                    data_oe_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    inh_cnt_d = inh_cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                clk_oe_d  = 1'b0;
                to_cnt_d  = '0;
                bit_cnt_d = '0;
                state_d   = BITS;
            end
            default: begin
                // BITS, ACK and WAIT_IDLE all share the transfer watchdog.
                if (to_cnt_q == TO_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (state_q == BITS) begin
                        if (clk_fall) begin
                            data_oe_d = ~shift_q[0];
                            shift_d   = {1'b1, shift_q[FRAME_LEN-1:1]};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_d = ACK;
                            end
                        end
                    end else if (state_q == ACK) begin
                        if (clk_fall) begin
                            ack_ok_d = ~data_sync;
                            state_d  = WAIT_IDLE;
                        end
                    end else if (clk_sync && data_sync) begin
                        done_d  = ack_ok_q;
                        error_d = ~ack_ok_q;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '1;
            ack_ok_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ack_ok_q  <= ack_ok_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // The result pulse lands in the first IDLE cycle; ready waits one more.
    assign tx_ready    = (state_q == IDLE) && !done_q && !error_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign dbg_state   = state_q;

endmodule
